// File: rtl/brlite_local_ni.sv
// PE-side network interface for the BrLite router LOCAL port. A TX FSM injects
// PE flits through the router's req/ack handshake, and an RX FIFO buffers delivered flits for the PE.
package brlite_local_ni_pkg;
  typedef logic [15:0] br_data_t;
endpackage

module brlite_local_ni
  import brlite_local_ni_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  br_data_t                    pe_tx_data_i,
  input  logic                        pe_tx_valid_i,
  output logic                        pe_tx_ready_o,
  output br_data_t                    noc_flit_o,
  output logic                        noc_req_o,
  input  logic                        noc_ack_i,
  input  logic                        noc_busy_i,
  input  br_data_t                    noc_flit_i,
  input  logic                        noc_req_i,
  output logic                        noc_ack_o,
  output br_data_t                    pe_rx_data_o,
  output logic                        pe_rx_valid_o,
  input  logic                        pe_rx_ready_i,
  output logic [$clog2(RX_DEPTH):0]   rx_level_o,
  output logic [CNT_W-1:0]            tx_cnt_o,
  output logic [CNT_W-1:0]            rx_cnt_o,
  output logic [1:0]                  tx_state_o
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Handshakes: a PE-side transfer happens on a rising edge where valid and
  // ready are both high; a NoC-side transfer on an edge where req and ack are
  // both high. The offering side holds data stable until that edge.

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_WAIT = 2'd1,
    TX_SEND = 2'd2
  } tx_state_t;

  tx_state_t tx_state;
  tx_state_t tx_next;
  br_data_t  tx_reg;

  assign noc_flit_o = tx_reg;
  assign tx_state_o = tx_state;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (pe_tx_valid_i && pe_tx_ready_o) tx_next = TX_WAIT;
      TX_WAIT: if (!noc_busy_i) tx_next = TX_SEND;
      // Busy is deliberately ignored here: once req is up it holds until ack.
      TX_SEND: if (noc_req_o && noc_ack_i) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state      <= TX_IDLE;
      pe_tx_ready_o <= 1'b0;
      noc_req_o     <= 1'b0;
      tx_reg        <= '0;
      tx_cnt_o      <= '0;
    end else begin
      tx_state      <= tx_next;
      pe_tx_ready_o <= (tx_next == TX_IDLE);
      noc_req_o     <= (tx_next == TX_SEND);
      if (tx_state == TX_IDLE && pe_tx_valid_i && pe_tx_ready_o) tx_reg <= pe_tx_data_i;
      if (noc_req_o && noc_ack_i) tx_cnt_o <= tx_cnt_o + CNT_W'(1);
    end
  end

  br_data_t         rx_mem [RX_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr;
  logic [PTR_W-1:0] rx_rd_ptr;
  logic             rx_full;
  logic             rx_push;
  logic             rx_pop;

  // Ack is a function of registered level only, never of pe_rx_ready_i.
  assign rx_full       = (rx_level_o == LVL_W'(RX_DEPTH));
  assign noc_ack_o     = !rx_full && !rst_i;
  assign pe_rx_valid_o = (rx_level_o != '0);
  assign pe_rx_data_o  = rx_mem[rx_rd_ptr];
  assign rx_push       = noc_req_i && noc_ack_o;
  assign rx_pop        = pe_rx_valid_o && pe_rx_ready_i;

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= noc_flit_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_level_o <= '0;
      rx_cnt_o   <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
        rx_cnt_o  <= rx_cnt_o + CNT_W'(1);
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_level_o <= rx_level_o + LVL_W'(1);
        2'b01:   rx_level_o <= rx_level_o - LVL_W'(1);
        default: rx_level_o <= rx_level_o;
      endcase
    end
  end

endmodule

// File: tb/tb_brlite_local_ni.sv
// Directed bench for brlite_local_ni (RX_DEPTH=4, CNT_W=4): TX timing and
// busy hold-off, RX fill/backpressure, push/pop ordering, reset, counter wrap.
module tb_brlite_local_ni;
  import brlite_local_ni_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  br_data_t   pe_tx_data = '0;
  logic       pe_tx_valid = 1'b0;
  logic       pe_tx_ready;
  br_data_t   noc_flit_o;
  logic       noc_req_o;
  logic       noc_ack_i = 1'b0;
  logic       noc_busy = 1'b0;
  br_data_t   noc_flit_i = '0;
  logic       noc_req_i = 1'b0;
  logic       noc_ack_o;
  br_data_t   pe_rx_data;
  logic       pe_rx_valid;
  logic       pe_rx_ready = 1'b0;
  logic [2:0] rx_level;
  logic [3:0] tx_cnt;
  logic [3:0] rx_cnt;
  logic [1:0] tx_state;

  int n_checks = 0;
  int n_errors = 0;
  int rx_next;
  int rx_last;
  int rx_got;
  logic [15:0] exp_q[$];

  brlite_local_ni #(.RX_DEPTH(4), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .pe_tx_data_i(pe_tx_data), .pe_tx_valid_i(pe_tx_valid), .pe_tx_ready_o(pe_tx_ready),
    .noc_flit_o(noc_flit_o), .noc_req_o(noc_req_o), .noc_ack_i(noc_ack_i), .noc_busy_i(noc_busy),
    .noc_flit_i(noc_flit_i), .noc_req_i(noc_req_i), .noc_ack_o(noc_ack_o),
    .pe_rx_data_o(pe_rx_data), .pe_rx_valid_o(pe_rx_valid), .pe_rx_ready_i(pe_rx_ready),
    .rx_level_o(rx_level), .tx_cnt_o(tx_cnt), .rx_cnt_o(rx_cnt), .tx_state_o(tx_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // driver: one PE injection with the router acking immediately
  task automatic inject(input br_data_t d);
    int t;
    t = 0;
    while (!pe_tx_ready && t < 10) begin tick(); t++; end
    pe_tx_valid = 1'b1;
    pe_tx_data  = d;
    tick();
    pe_tx_valid = 1'b0;
    t = 0;
    while (!(noc_req_o && noc_ack_i) && t < 10) begin tick(); t++; end
    n_checks++;
    if (t >= 10) begin
      n_errors++;
      $display("FAIL inject_timeout: req never rose for data %h", d);
    end else begin
      tick();
    end
  endtask

  // driver + scoreboard: one cycle of router-side push and PE-side pop
  task automatic rx_cycle();
    logic xfer;
    logic consume;
    logic [15:0] exp_v;
    xfer    = noc_req_i && noc_ack_o;
    consume = pe_rx_valid && pe_rx_ready;
    if (consume) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rx_order: got %h, nothing expected", pe_rx_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (pe_rx_data !== exp_v) begin
          n_errors++;
          $display("FAIL rx_order: got %h expected %h", pe_rx_data, exp_v);
        end
      end
      rx_got++;
    end
    if (xfer) exp_q.push_back(noc_flit_i);
    tick();
    if (xfer) begin
      rx_next++;
      if (rx_next > rx_last) noc_req_i = 1'b0;
      else noc_flit_i = br_data_t'(rx_next);
    end
  endtask

  task automatic rx_drain();
    int t;
    pe_rx_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || noc_req_i) && t < 40) begin rx_cycle(); t++; end
    n_checks++;
    if (t >= 40) begin
      n_errors++;
      $display("FAIL rx_drain_timeout: %0d entries left", exp_q.size());
    end
    pe_rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if ({pe_tx_ready, noc_req_o, noc_ack_o, pe_rx_valid} !== 4'b0000 || noc_flit_o !== '0 ||
        rx_level !== 3'd0 || tx_cnt !== 4'd0 || rx_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_values: rdy=%b req=%b ack=%b vld=%b flit=%h lvl=%0d tx=%0d rx=%0d",
               pe_tx_ready, noc_req_o, noc_ack_o, pe_rx_valid, noc_flit_o, rx_level, tx_cnt, rx_cnt);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (pe_tx_ready !== 1'b0 || noc_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release: rdy=%b ack=%b expected 0 1", pe_tx_ready, noc_ack_o);
    end
    tick();
    n_checks++;
    if (pe_tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_reset: got %b expected 1", pe_tx_ready);
    end
  endtask

  task automatic test_single_tx();
    noc_busy = 1'b0;
    noc_ack_i = 1'b1;
    pe_tx_data = 16'h00A5;
    pe_tx_valid = 1'b1;
    tick();
    pe_tx_valid = 1'b0;
    n_checks++;
    if (pe_tx_ready !== 1'b0 || noc_req_o !== 1'b0 || noc_flit_o !== 16'h00A5) begin
      n_errors++;
      $display("FAIL tx_capture: rdy=%b req=%b flit=%h expected 0 0 00a5", pe_tx_ready, noc_req_o, noc_flit_o);
    end
    tick();
    n_checks++;
    if (noc_req_o !== 1'b1 || noc_flit_o !== 16'h00A5 || pe_tx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL tx_send: req=%b flit=%h rdy=%b expected 1 00a5 0", noc_req_o, noc_flit_o, pe_tx_ready);
    end
    tick();
    n_checks++;
    if (noc_req_o !== 1'b0 || pe_tx_ready !== 1'b1 || tx_cnt !== 4'd1) begin
      n_errors++;
      $display("FAIL tx_done: req=%b rdy=%b cnt=%0d expected 0 1 1", noc_req_o, pe_tx_ready, tx_cnt);
    end
  endtask

  task automatic test_busy_holdoff();
    noc_busy = 1'b1;
    pe_tx_data = 16'h003C;
    pe_tx_valid = 1'b1;
    tick();
    pe_tx_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (noc_req_o !== 1'b0) begin
        n_errors++;
        $display("FAIL busy_holdoff cycle %0d: req=%b expected 0", i, noc_req_o);
      end
    end
    noc_busy = 1'b0;
    noc_ack_i = 1'b0;
    tick();
    n_checks++;
    if (noc_req_o !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_release: req=%b expected 1", noc_req_o);
    end
    for (int i = 0; i < 4; i++) begin
      noc_busy = ~noc_busy;
      tick();
      n_checks++;
      if (noc_req_o !== 1'b1 || noc_flit_o !== 16'h003C || tx_cnt !== 4'd1) begin
        n_errors++;
        $display("FAIL send_stable cycle %0d: req=%b flit=%h cnt=%0d expected 1 003c 1", i, noc_req_o, noc_flit_o, tx_cnt);
      end
    end
    noc_busy = 1'b0;
    noc_ack_i = 1'b1;
    tick();
    n_checks++;
    if (noc_req_o !== 1'b0 || pe_tx_ready !== 1'b1 || tx_cnt !== 4'd2) begin
      n_errors++;
      $display("FAIL busy_done: req=%b rdy=%b cnt=%0d expected 0 1 2", noc_req_o, pe_tx_ready, tx_cnt);
    end
  endtask

  task automatic test_rx_fill();
    rx_got = 0;
    rx_next = 1;
    rx_last = 6;
    noc_flit_i = 16'd1;
    noc_req_i = 1'b1;
    pe_rx_ready = 1'b0;
    for (int i = 0; i < 6; i++) rx_cycle();
    n_checks++;
    if (rx_level !== 3'd4 || noc_ack_o !== 1'b0 || rx_cnt !== 4'd4 || pe_rx_data !== 16'd1 || noc_flit_i !== 16'd5) begin
      n_errors++;
      $display("FAIL rx_full: lvl=%0d ack=%b cnt=%0d head=%h offered=%h expected 4 0 4 0001 0005",
               rx_level, noc_ack_o, rx_cnt, pe_rx_data, noc_flit_i);
    end
    pe_rx_ready = 1'b1;
    rx_cycle();
    pe_rx_ready = 1'b0;
    n_checks++;
    if (noc_ack_o !== 1'b1 || rx_level !== 3'd3) begin
      n_errors++;
      $display("FAIL rx_pop_ack: ack=%b lvl=%0d expected 1 3", noc_ack_o, rx_level);
    end
    rx_cycle();
    n_checks++;
    if (rx_level !== 3'd4 || noc_ack_o !== 1'b0 || noc_flit_i !== 16'd6) begin
      n_errors++;
      $display("FAIL rx_refill: lvl=%0d ack=%b offered=%h expected 4 0 0006", rx_level, noc_ack_o, noc_flit_i);
    end
    rx_drain();
    n_checks++;
    if (rx_got !== 6 || rx_level !== 3'd0 || pe_rx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rx_fill_total: got %0d lvl=%0d vld=%b expected 6 0 0", rx_got, rx_level, pe_rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    rx_got = 0;
    rx_next = 16'h10;
    rx_last = 16'h10 + 13;
    noc_flit_i = 16'h10;
    noc_req_i = 1'b1;
    pe_rx_ready = 1'b0;
    rx_cycle();
    rx_cycle();
    pe_rx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx_cycle();
      n_checks++;
      if (rx_level !== 3'd2 || noc_ack_o !== 1'b1) begin
        n_errors++;
        $display("FAIL push_pop_level cycle %0d: lvl=%0d ack=%b expected 2 1", i, rx_level, noc_ack_o);
      end
    end
    rx_drain();
    n_checks++;
    if (rx_got !== 14 || rx_level !== 3'd0) begin
      n_errors++;
      $display("FAIL push_pop_total: got %0d lvl=%0d expected 14 0", rx_got, rx_level);
    end
  endtask

  task automatic test_reset_mid_send();
    noc_flit_i = 16'h00EE;
    noc_req_i = 1'b1;
    tick();
    noc_req_i = 1'b0;
    noc_busy = 1'b0;
    noc_ack_i = 1'b0;
    pe_tx_data = 16'h005A;
    pe_tx_valid = 1'b1;
    tick();
    pe_tx_valid = 1'b0;
    tick();
    n_checks++;
    if (noc_req_o !== 1'b1 || rx_level !== 3'd1) begin
      n_errors++;
      $display("FAIL pre_reset: req=%b lvl=%0d expected 1 1", noc_req_o, rx_level);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (noc_req_o !== 1'b0 || noc_ack_o !== 1'b0 || tx_cnt !== 4'd0 || rx_cnt !== 4'd0 ||
        rx_level !== 3'd0 || pe_rx_valid !== 1'b0 || noc_flit_o !== '0) begin
      n_errors++;
      $display("FAIL async_reset: req=%b ack=%b tx=%0d rx=%0d lvl=%0d vld=%b flit=%h expected all 0",
               noc_req_o, noc_ack_o, tx_cnt, rx_cnt, rx_level, pe_rx_valid, noc_flit_o);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    noc_ack_i = 1'b1;
    inject(16'h0077);
    n_checks++;
    if (tx_cnt !== 4'd1 || noc_flit_o !== 16'h0077 || pe_tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_tx: cnt=%0d flit=%h rdy=%b expected 1 0077 1", tx_cnt, noc_flit_o, pe_tx_ready);
    end
    rx_got = 0;
    rx_next = 16'h99;
    rx_last = 16'h99;
    noc_flit_i = 16'h99;
    noc_req_i = 1'b1;
    rx_drain();
    n_checks++;
    if (rx_got !== 1 || rx_cnt !== 4'd1) begin
      n_errors++;
      $display("FAIL post_reset_rx: got %0d cnt=%0d expected 1 1", rx_got, rx_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    noc_busy = 1'b0;
    noc_ack_i = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      inject(br_data_t'(i));
      if (i == 15 || i == 16) begin
        n_checks++;
        if (tx_cnt !== 4'(i)) begin
          n_errors++;
          $display("FAIL tx_cnt_%0d: got %0d expected %0d", i, tx_cnt, 4'(i));
        end
      end
    end
    n_checks++;
    if (tx_cnt !== 4'd1) begin
      n_errors++;
      $display("FAIL tx_cnt_wrap: got %0d expected 1", tx_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_busy_holdoff();
    test_rx_fill();
    test_back_to_back();
    test_reset_mid_send();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
